// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//  Groups the producer write port and the uart_tx launch/handshake port of
//  uart_tx_fifo into one bundle.
//  master : drives i_Wr_DV, i_Wr_Byte (producer side) and i_Tx_Active,
//           i_Tx_Done (uart_tx side); observes every FIFO output.
//  slave  : the FIFO itself; drives o_Full, o_Empty, o_Overflow, o_Busy,
//           o_Tx_DV, o_Tx_Byte (and o_Count when present).
//  Optional feature macro: UART_TX_FIFO_CNT_EN adds the o_Count occupancy
//  signal and the ADDR_W parameter that sizes it.
interface uart_tx_fifo_if
`ifdef UART_TX_FIFO_CNT_EN
#(
    parameter int ADDR_W = 4
)
`endif
;
    logic       i_Wr_DV;
    logic [7:0] i_Wr_Byte;
    logic       o_Full;
    logic       o_Empty;
    logic       o_Overflow;
    logic       o_Busy;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active;
    logic       i_Tx_Done;
`ifdef UART_TX_FIFO_CNT_EN
    logic [ADDR_W:0] o_Count;
`endif

    modport master (
`ifdef UART_TX_FIFO_CNT_EN
        input  o_Count,
`endif
        output i_Wr_DV,
        output i_Wr_Byte,
        output i_Tx_Active,
        output i_Tx_Done,
        input  o_Full,
        input  o_Empty,
        input  o_Overflow,
        input  o_Busy,
        input  o_Tx_DV,
        input  o_Tx_Byte
    );

    modport slave (
`ifdef UART_TX_FIFO_CNT_EN
        output o_Count,
`endif
        input  i_Wr_DV,
        input  i_Wr_Byte,
        input  i_Tx_Active,
        input  i_Tx_Done,
        output o_Full,
        output o_Empty,
        output o_Overflow,
        output o_Busy,
        output o_Tx_DV,
        output o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//  Byte FIFO placed directly in front of uart_tx. Producers push bursts of
//  bytes; the FIFO launches them into uart_tx one frame at a time and waits
//  for each frame to complete before launching the next.
//  Ports:
//   i_Clock  : system clock, rising edge
//   i_Reset  : synchronous active-high reset; queued bytes are discarded
//   bus      : uart_tx_fifo_if.slave
//              i_Wr_DV/i_Wr_Byte   write strobe and byte
//              o_Full/o_Empty      occupancy flags from registered pointers
//              o_Overflow          1-cycle pulse when a write hits a full FIFO
//              o_Busy              FIFO non-empty or a frame is in progress
//              o_Tx_DV/o_Tx_Byte   launch pulse and byte to uart_tx
//              i_Tx_Active/Done    status back from uart_tx
//              o_Count             occupancy 0..DEPTH (UART_TX_FIFO_CNT_EN only)
//  Optional feature macro: UART_TX_FIFO_CNT_EN enables o_Count.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    uart_tx_fifo_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            wr_en;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // when the low address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // Full is taken from the registered pointers, so a write arriving while
    // full is dropped even if a pop happens on the same edge.
    assign wr_en = bus.i_Wr_DV && !full;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        overflow_d = bus.i_Wr_DV && full;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // Launch only when uart_tx is completely quiet; this also holds off a
    // launch after a reset that interrupted a frame uart_tx is still sending.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !bus.i_Tx_Active && !bus.i_Tx_Done) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i_Tx_Done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!bus.i_Tx_Done && !bus.i_Tx_Active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; resetting the pointers is what discards contents.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.i_Wr_Byte;
        end
    end

    assign bus.o_Full     = full;
    assign bus.o_Empty    = empty;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Busy     = !empty || (state_q != S_IDLE);
    assign bus.o_Tx_DV    = tx_dv_q;
    assign bus.o_Tx_Byte  = tx_byte_q;

`ifdef UART_TX_FIFO_CNT_EN
    assign bus.o_Count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//  Directed self-checking bench for uart_tx_fifo. A small behavioural stand-in
//  for uart_tx accepts each launch, records the byte, holds i_Tx_Active for a
//  short frame and then raises i_Tx_Done for two cycles.
//  Optional feature macro: UART_TX_FIFO_CNT_EN enables the o_Count checks.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int FRAME_CYC = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef UART_TX_FIFO_CNT_EN
    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus();
`else
    uart_tx_fifo_if bus();
`endif

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus    (bus.slave)
    );

    int         check_cnt    = 0;
    int         pass_cnt     = 0;
    int         launch_cnt   = 0;
    int         launch_err   = 0;
    int         ovf_samples  = 0;
    int         full_samples = 0;
    int         max_count    = 0;
    bit         model_busy   = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];

    // Every comparison funnels through here so the counts stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    // Writes every byte of stim_q on back-to-back cycles.
    task automatic applyStimulus();
        foreach (stim_q[i]) begin
            @(negedge clk);
            bus.i_Wr_DV   = 1'b1;
            bus.i_Wr_Byte = stim_q[i];
        end
        @(negedge clk);
        bus.i_Wr_DV = 1'b0;
    endtask

    // Waits for the FIFO and the uart_tx stand-in to both go quiet.
    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((bus.o_Busy || model_busy) && n < budget);
        checkOutput(tag, 32'(!(bus.o_Busy || model_busy)), 32'd1);
    endtask

    // uart_tx stand-in. Any launch seen while a frame is in flight is an error.
    initial begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_Tx_DV === 1'b1) begin
                if (bus.i_Tx_Active || bus.i_Tx_Done) begin
                    launch_err++;
                end
                rx_q.push_back(bus.o_Tx_Byte);
                launch_cnt++;
                model_busy      = 1'b1;
                bus.i_Tx_Active = 1'b1;
                repeat (FRAME_CYC) begin
                    @(posedge clk);
                    #1;
                    if (bus.o_Tx_DV !== 1'b0) launch_err++;
                end
                bus.i_Tx_Active = 1'b0;
                bus.i_Tx_Done   = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    if (bus.o_Tx_DV !== 1'b0) launch_err++;
                end
                bus.i_Tx_Done = 1'b0;
                model_busy    = 1'b0;
            end
        end
    end

    // Flag monitor sampled once per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_Overflow === 1'b1) ovf_samples++;
            if (bus.o_Full === 1'b1) full_samples++;
`ifdef UART_TX_FIFO_CNT_EN
            if (int'(bus.o_Count) > max_count) max_count = int'(bus.o_Count);
`endif
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ovf_before;
        int full_before;
        int launch_before;

        rst           = 1'b1;
        bus.i_Wr_DV   = 1'b0;
        bus.i_Wr_Byte = 8'h00;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tx_dv",    32'(bus.o_Tx_DV),    32'd0);
        checkOutput("rst_tx_byte",  32'(bus.o_Tx_Byte),  32'h00);
        checkOutput("rst_overflow", 32'(bus.o_Overflow), 32'd0);
        checkOutput("rst_empty",    32'(bus.o_Empty),    32'd1);
        checkOutput("rst_full",     32'(bus.o_Full),     32'd0);
        checkOutput("rst_busy",     32'(bus.o_Busy),     32'd0);
`ifdef UART_TX_FIFO_CNT_EN
        checkOutput("rst_count",    32'(bus.o_Count),    32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single byte: launch one cycle after the write edge, one cycle wide.
        @(negedge clk);
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = 8'hAB;
        @(posedge clk);
        #1;
        checkOutput("s2_empty_after_wr", 32'(bus.o_Empty), 32'd0);
        checkOutput("s2_dv_not_yet",     32'(bus.o_Tx_DV), 32'd0);
        @(negedge clk);
        bus.i_Wr_DV = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s2_dv_launch",   32'(bus.o_Tx_DV),   32'd1);
        checkOutput("s2_byte_launch", 32'(bus.o_Tx_Byte), 32'hAB);
        checkOutput("s2_empty_pop",   32'(bus.o_Empty),   32'd1);
        checkOutput("s2_busy_frame",  32'(bus.o_Busy),    32'd1);
        @(posedge clk);
        #1;
        checkOutput("s2_dv_one_cycle", 32'(bus.o_Tx_DV),   32'd0);
        checkOutput("s2_byte_held",    32'(bus.o_Tx_Byte), 32'hAB);
        exp_q.push_back(8'hAB);
        waitIdle("s2_idle", 200);
        checkOutput("s2_empty_end", 32'(bus.o_Empty), 32'd1);
        checkOutput("s2_busy_end",  32'(bus.o_Busy),  32'd0);

        // Three bytes back-to-back.
        stim_q = '{8'hAB, 8'h32, 8'h55};
        applyStimulus();
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h55);
        waitIdle("s3_idle", 500);
        checkOutput("s3_launches", 32'(launch_cnt), 32'd4);

        // Eighteen bytes: 0x00 launches, 0x01..0x10 fill, 0x11 overflows.
        ovf_before  = ovf_samples;
        full_before = full_samples;
        stim_q.delete();
        for (int b = 0; b < 18; b++) stim_q.push_back(8'(b));
        applyStimulus();
        checkOutput("s4_full",          32'(bus.o_Full),     32'd1);
        checkOutput("s4_overflow",      32'(bus.o_Overflow), 32'd1);
`ifdef UART_TX_FIFO_CNT_EN
        checkOutput("s4_count_full",    32'(bus.o_Count),    32'd16);
`endif
        @(posedge clk);
        #1;
        checkOutput("s4_overflow_pulse", 32'(bus.o_Overflow), 32'd0);
        for (int b = 0; b < 17; b++) exp_q.push_back(8'(b));
        waitIdle("s4_idle", 2000);
        checkOutput("s4_ovf_samples", 32'(ovf_samples - ovf_before), 32'd1);
        checkOutput("s4_full_seen",   32'(full_samples > full_before), 32'd1);
        checkOutput("s4_empty_end",   32'(bus.o_Empty), 32'd1);
`ifdef UART_TX_FIFO_CNT_EN
        checkOutput("s4_count_max",   32'(max_count),   32'd16);
        checkOutput("s4_count_end",   32'(bus.o_Count), 32'd0);
`endif

        // Reset mid-frame, then a new byte written while uart_tx is still busy.
        launch_before = launch_cnt;
        stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        applyStimulus();
        exp_q.push_back(8'hC1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("s5_mid_frame",    32'(model_busy),     32'd1);
        checkOutput("s5_rst_empty",    32'(bus.o_Empty),    32'd1);
        checkOutput("s5_rst_busy",     32'(bus.o_Busy),     32'd0);
        checkOutput("s5_rst_dv",       32'(bus.o_Tx_DV),    32'd0);
        checkOutput("s5_rst_byte",     32'(bus.o_Tx_Byte),  32'h00);
        stim_q = '{8'h5A};
        applyStimulus();
        exp_q.push_back(8'h5A);
        waitIdle("s5_idle", 500);
        checkOutput("s5_launches", 32'(launch_cnt - launch_before), 32'd2);

        // Whole-run ordering and launch discipline.
        checkOutput("launch_guard", 32'(launch_err), 32'd0);
        checkOutput("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) begin
                checkOutput($sformatf("rx_byte_%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
